// File: rtl/des_decrypt_iter.sv
// Iterative DES decryption: one Feistel round per clock, 17 clocks from START to DONE.
// Optional key-parity check is enabled by defining DES_DECRYPT_PARITY_EN.
module des_decrypt_iter (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [63:0] KEY,
  input  logic [63:0] CIPHER_TEXT,
  output logic [63:0] PLAIN_TEXT,
  output logic        BUSY,
`ifdef DES_DECRYPT_PARITY_EN
  output logic        KEY_PARITY_ERR,
`endif
  output logic        DONE
);

  typedef enum logic [1:0] {IDLE, ROUND, FINISH} state_t;

  // Tables use DES numbering: entry t selects bit t, where bit 1 is the MSB.
  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,  8,  9, 10, 11,
    12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
    22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  // S-boxes flattened as box*64 + row*16 + column.
  localparam int SBOX [512] = '{
    14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
     0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
     4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
    15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13,
    15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
     3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
     0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
    13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9,
    10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
    13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
    13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
     1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12,
     7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
    13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
    10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
     3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14,
     2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
    14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
     4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
    11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3,
    12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
    10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
     9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
     4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13,
     4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
    13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
     1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
     6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12,
    13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
     1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
     7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
     2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11};

  function automatic logic [63:0] permIp(input logic [63:0] x);
    permIp = '0;
    for (int i = 0; i < 64; i++) permIp[6'(63 - i)] = x[6'(64 - IP_T[i])];
  endfunction

  function automatic logic [63:0] permFp(input logic [63:0] x);
    permFp = '0;
    for (int i = 0; i < 64; i++) permFp[6'(63 - i)] = x[6'(64 - FP_T[i])];
  endfunction

  function automatic logic [55:0] permPc1(input logic [63:0] k);
    permPc1 = '0;
    for (int i = 0; i < 56; i++) permPc1[6'(55 - i)] = k[6'(64 - PC1_T[i])];
  endfunction

  function automatic logic [47:0] permPc2(input logic [55:0] cd);
    permPc2 = '0;
    for (int i = 0; i < 48; i++) permPc2[6'(47 - i)] = cd[6'(56 - PC2_T[i])];
  endfunction

  function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s;
    logic [5:0]  b;
    x = '0;
    s = '0;
    for (int i = 0; i < 48; i++) x[6'(47 - i)] = r[5'(32 - E_T[i])];
    x = x ^ k;
    for (int j = 0; j < 8; j++) begin
      b = x[6'(47 - 6 * j) -: 6];
      s[5'(31 - 4 * j) -: 4] = 4'(SBOX[{3'(j), b[5], b[0], b[4:1]}]);
    end
    feistel = '0;
    for (int i = 0; i < 32; i++) feistel[5'(31 - i)] = s[5'(32 - P_T[i])];
  endfunction

  state_t      state_q;
  logic [31:0] l_q, r_q, r_d;
  logic [27:0] c_q, d_q, c_d, d_d;
  logic [3:0]  cnt_q;
  logic [63:0] plain_q, ip_d, fp_d;
  logic [55:0] pc1_d;
  logic [47:0] subkey_d;
  logic        busy_q, done_q, keyOk_d;

  // Key schedule runs backwards: C/D start at C16/D16 (= C0/D0) and rotate right.
  always_comb begin
    ip_d  = permIp(CIPHER_TEXT);
    pc1_d = permPc1(KEY);
    unique case (cnt_q)
      4'd0:               begin c_d = c_q;                d_d = d_q;                end
      4'd1, 4'd8, 4'd15:  begin c_d = {c_q[0], c_q[27:1]};   d_d = {d_q[0], d_q[27:1]};   end
      default:            begin c_d = {c_q[1:0], c_q[27:2]}; d_d = {d_q[1:0], d_q[27:2]}; end
    endcase
    subkey_d = permPc2({c_d, d_d});
    r_d      = l_q ^ feistel(r_q, subkey_d);
    fp_d     = permFp({r_q, l_q});
    keyOk_d  = 1'b1;
`ifdef DES_DECRYPT_PARITY_EN
    for (int i = 0; i < 8; i++) if (!(^KEY[6'(8 * i) +: 8])) keyOk_d = 1'b0;
`endif
  end

`ifdef DES_DECRYPT_PARITY_EN
  logic perr_q;
  assign KEY_PARITY_ERR = perr_q;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      l_q     <= '0;
      r_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      plain_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef DES_DECRYPT_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef DES_DECRYPT_PARITY_EN
      perr_q <= (state_q == IDLE) && START && !keyOk_d;
`endif
      unique case (state_q)
        IDLE: begin
          if (START && keyOk_d) begin
            l_q     <= ip_d[63:32];
            r_q     <= ip_d[31:0];
            c_q     <= pc1_d[55:28];
            d_q     <= pc1_d[27:0];
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ROUND;
          end else begin
            busy_q  <= 1'b0;
          end
        end
        ROUND: begin
          l_q   <= r_q;
          r_q   <= r_d;
          c_q   <= c_d;
          d_q   <= d_d;
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) state_q <= FINISH;
        end
        FINISH: begin
          plain_q <= fp_d;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign PLAIN_TEXT = plain_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;

endmodule
